i2c_master_arbiter: RTL and testbench
=====================================

# i2c_master_arbiter

Round-robin arbiter and sequencer sharing one `I2C_MASTER` between `N_REQ` client blocks. It takes single-byte read or write requests, issues each to the master with a one-cycle enable pulse, and waits for completion or timeout. It then returns the result (read byte, error flag) to the owning client. It sits between the client logic and the master instance, which shares `clk` and `reset_n`.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TIMEOUT_CYCLES`, default 4096: maximum cycles from issue to master `done` before the transaction is abandoned.
- `clk`, input, 1: clock.
- `reset_n`, input, 1: reset, asynchronous, active-low.
- `req`, input, N_REQ: per-client request level, held until that client's `rsp_valid`.
- `req_mode`, input, N_REQ: per-client 0 = write, 1 = read.
- `req_addr`, input, 7*N_REQ: per-client 7-bit slave address; client i uses bits [7i+6:7i].
- `req_data`, input, 8*N_REQ: per-client write byte; client i uses bits [8i+7:8i].
- `req_stop`, input, N_REQ: per-client stop flag, passed through to the master.
- `gnt`, output, N_REQ: one-hot owner of the current transaction; held from ISSUE through RESPOND.
- `rsp_valid`, output, N_REQ: one-cycle one-hot completion pulse to the owner.
- `rsp_data`, output, 8: received byte; valid with `rsp_valid`; 0 for writes.
- `rsp_error`, output, 1: set with `rsp_valid` on NACK or on timeout.
- `rsp_timeout`, output, 1: set with `rsp_valid` on timeout only.
- `m_enable`, output, 1: start pulse to the master.
- `m_mode`, output, 1: transaction mode to the master.
- `m_slave_addr`, output, 7: slave address to the master.
- `m_data`, output, 8: write byte to the master.
- `m_stop`, output, 1: stop flag to the master.
- `m_busy`, input, 1: master busy.
- `m_done`, input, 1: master completion pulse.
- `m_error`, input, 1: master error flag.
- `m_recv_buf`, input, 8: master received byte.

## Operation
- All outputs are registered.
- Reset values: `gnt`, `rsp_valid`, `rsp_data`, `rsp_error`, `rsp_timeout`, `m_enable`, `m_mode`, `m_stop`, `m_slave_addr`, `m_data` = 0; state = IDLE; round-robin pointer `last` = N_REQ-1; timeout counter = 0.
- State IDLE:
  - Leave only if `req` is non-zero and `m_busy` = 0.
  - Winner is the first set bit searching upward from `last`+1, wrapping modulo N_REQ.
  - Latch the winner's mode, address, data and stop into the `m_*` registers.
  - Set `gnt`, update `last` to the winner, go to ISSUE.
- State ISSUE: `m_enable` = 1 for exactly this cycle; clear the counter; go to WAIT_DONE.
- State WAIT_DONE:
  - Counter increments each cycle.
  - On `m_done` = 1: capture `m_recv_buf` (reads) or 0 (writes) and `m_error`; go to RESPOND.
  - Else if counter = TIMEOUT_CYCLES-1: set the timeout and error flags; go to RESPOND.
  - If `m_done` and the timeout coincide, `m_done` wins: no timeout is reported.
- State RESPOND: `rsp_valid[owner]` = 1 with `rsp_data`, `rsp_error`, `rsp_timeout` for one cycle; next state IDLE; `gnt` clears on leaving RESPOND.
- `m_error` stays high through the master's STOP/DONE, so sampling it on `m_done` is valid.
- `m_*` operand registers hold their values until the next grant.
- A client dropping `req` mid-transaction has no effect: the transaction completes and `rsp_valid` still pulses.
- A client re-asserting `req` in the cycle after its `rsp_valid` is treated as a new request, subject to round-robin.
- After a timeout the master may still be busy; IDLE waits for `m_busy` = 0 before issuing again. No abort is sent.
- Reset mid-transaction returns everything to reset values immediately; no response is emitted.

## Timing
- `req` sampled in IDLE at edge k → `gnt` and `m_*` operands valid from cycle k+1, `m_enable` high in cycle k+1 only.
- `m_done` sampled at edge j → `rsp_valid` high in cycle j+1.
- Back-to-back: the next `m_enable` comes no earlier than 2 cycles after `rsp_valid`, via RESPOND→IDLE→ISSUE.
- Fairness: with all clients requesting continuously, each is granted once every N_REQ transactions.

## Structure
- Shared package `i2c_pkg` holds:
  - state encodings IDLE, ISSUE, WAIT_DONE, RESPOND;
  - MODE_WRITE = 0, MODE_READ = 1;
  - widths ADDR_W = 7, DATA_W = 8.
- One natural sub-module, `rr_pick`: combinational round-robin selector. Inputs `req` and `last`; outputs one-hot `win` and its index.
- Counter width is $clog2(TIMEOUT_CYCLES).

## Test plan
- Single write: client 2 requests a write to addr 0x50, data 0xA5, stop 1, and the master ACKs. Expect:
  - `m_enable` for one cycle with `m_slave_addr` = 0x50, `m_data` = 0xA5;
  - `rsp_valid` = 4'b0100, `rsp_error` = 0, `rsp_data` = 0.
- Read: client 0 reads addr 0x3C and the slave returns 0x5A. Expect `rsp_valid[0]`, `rsp_data` = 0x5A, `rsp_error` = 0.
- NACK: the master raises `m_error` before `m_done`. Expect `rsp_error` = 1, `rsp_timeout` = 0, and the next request still served.
- Round-robin: all four clients hold `req` from reset. Expect grant order 0, 1, 2, 3, 0, with no client granted twice before the others.
- Timeout: TIMEOUT_CYCLES = 16 and `m_done` never arrives. Expect `rsp_valid` 17 cycles after `m_enable` with `rsp_error` = `rsp_timeout` = 1, and no new `m_enable` while `m_busy` = 1.
- Reset mid-op: pull `reset_n` low during WAIT_DONE. Expect all outputs 0 immediately, no `rsp_valid`, and the first grant after reset goes to client 0.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master arbiter: FSM encodings, transfer modes, bus widths.
package i2c_pkg;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    localparam logic MODE_WRITE = 1'b0;
    localparam logic MODE_READ  = 1'b1;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_DONE = 2'd2;
    localparam logic [1:0] ST_RESPOND   = 2'd3;

    typedef struct packed {
        logic              mode;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              stop;
    } op_t;

endpackage

// File: rtl/i2c_master_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit searching upward from last+1, wrapping.
// Zero latency; no backpressure (pure function of req/last).
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [N_REQ-1:0] win,
    output logic [IDX_W-1:0] win_idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDX_W'((int'(last) + k) % N_REQ);
            if (!found && req[cand]) begin
                found     = 1'b1;
                win[cand] = 1'b1;
                win_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_master_arbiter.sv
// Round-robin sequencer sharing one I2C master among N_REQ clients, one byte per grant.
// req->m_enable 1 cycle, m_done->rsp_valid 1 cycle; holds off new grants while the master is busy.
module i2c_master_arbiter
    import i2c_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        req_mode,
    input  logic [ADDR_W*N_REQ-1:0] req_addr,
    input  logic [DATA_W*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]        req_stop,
    output logic [N_REQ-1:0]        gnt,
    output logic [N_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]       rsp_data,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    m_enable,
    output logic                    m_mode,
    output logic [ADDR_W-1:0]       m_slave_addr,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_stop,
    input  logic                    m_busy,
    input  logic                    m_done,
    input  logic                    m_error,
    input  logic [DATA_W-1:0]       m_recv_buf
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic [IDX_W-1:0] last;
    logic [CNT_W-1:0] cnt;
    logic [N_REQ-1:0] win;
    logic [IDX_W-1:0] win_idx;
    op_t              req_op [N_REQ];
    op_t              sel_op;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_op[i].mode = req_mode[i];
            req_op[i].addr = req_addr[ADDR_W*i +: ADDR_W];
            req_op[i].data = req_data[DATA_W*i +: DATA_W];
            req_op[i].stop = req_stop[i];
        end
    end

    assign sel_op = req_op[win_idx];

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .last    (last),
        .win     (win),
        .win_idx (win_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            last         <= IDX_W'(N_REQ - 1);
            cnt          <= '0;
            gnt          <= '0;
            rsp_valid    <= '0;
            rsp_data     <= '0;
            rsp_error    <= 1'b0;
            rsp_timeout  <= 1'b0;
            m_enable     <= 1'b0;
            m_mode       <= 1'b0;
            m_slave_addr <= '0;
            m_data       <= '0;
            m_stop       <= 1'b0;
        end else begin
            m_enable  <= 1'b0;
            rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    if (|req && !m_busy) begin
                        m_mode       <= sel_op.mode;
                        m_slave_addr <= sel_op.addr;
                        m_data       <= sel_op.data;
                        m_stop       <= sel_op.stop;
                        gnt          <= win;
                        last         <= win_idx;
                        m_enable     <= 1'b1;
                        state        <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    cnt   <= '0;
                    state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    cnt <= cnt + 1'b1;
                    // A done arriving on the final counted cycle beats the timeout.
                    if (m_done) begin
                        rsp_data    <= (m_mode == MODE_READ) ? m_recv_buf : '0;
                        rsp_error   <= m_error;
                        rsp_timeout <= 1'b0;
                        rsp_valid   <= gnt;
                        state       <= ST_RESPOND;
                    end else if (cnt == CNT_LAST) begin
                        rsp_data    <= '0;
                        rsp_error   <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_valid   <= gnt;
                        state       <= ST_RESPOND;
                    end
                end
                ST_RESPOND: begin
                    gnt         <= '0;
                    rsp_data    <= '0;
                    rsp_error   <= 1'b0;
                    rsp_timeout <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed bench for i2c_master_arbiter with a response scoreboard and a hand-driven master.
module tb_i2c_master_arbiter;
    import i2c_pkg::*;

    localparam int N  = 4;
    localparam int TO = 16;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req, req_mode, req_stop;
    logic [7*N-1:0] req_addr;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   gnt, rsp_valid;
    logic [7:0]     rsp_data;
    logic           rsp_error, rsp_timeout;
    logic           m_enable, m_mode, m_stop;
    logic [6:0]     m_slave_addr;
    logic [7:0]     m_data;
    logic           m_busy, m_done, m_error;
    logic [7:0]     m_recv_buf;

    always #5 clk = ~clk;

    i2c_master_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .req          (req),
        .req_mode     (req_mode),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_stop     (req_stop),
        .gnt          (gnt),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_error    (rsp_error),
        .rsp_timeout  (rsp_timeout),
        .m_enable     (m_enable),
        .m_mode       (m_mode),
        .m_slave_addr (m_slave_addr),
        .m_data       (m_data),
        .m_stop       (m_stop),
        .m_busy       (m_busy),
        .m_done       (m_done),
        .m_error      (m_error),
        .m_recv_buf   (m_recv_buf)
    );

    typedef struct {
        logic [N-1:0] valid;
        logic [7:0]   data;
        logic         err;
        logic         to;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a client request; the expected response is queued at the same time.
    task automatic post(input int c, input logic mode, input logic [6:0] addr, input logic [7:0] data,
                        input logic stop, input logic [7:0] rbuf, input logic err, input logic to,
                        input bit expect_rsp);
        exp_t e;
        req_mode[c]        = mode;
        req_addr[7*c +: 7] = addr;
        req_data[8*c +: 8] = data;
        req_stop[c]        = stop;
        req[c]             = 1'b1;
        if (expect_rsp) begin
            e.valid = N'(1 << c);
            e.data  = (mode == MODE_READ && !to) ? rbuf : 8'h00;
            e.err   = err | to;
            e.to    = to;
            sb.push_back(e);
        end
    endtask

    task automatic wait_enable(output bit ok);
        int k;
        ok = 1'b0;
        k  = 0;
        while (!ok && k < 60) begin
            @(negedge clk);
            if (m_enable) ok = 1'b1;
            k++;
        end
    endtask

    task automatic check_rsp();
        exp_t e;
        chk("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("rsp_valid", rsp_valid, e.valid);
            chk("rsp_data", rsp_data, e.data);
            chk("rsp_error", rsp_error, e.err);
            chk("rsp_timeout", rsp_timeout, e.to);
        end
    endtask

    // Act as the master for one transfer: check the issued operands, finish after delay cycles.
    task automatic serve(input int c, input logic mode, input logic [6:0] addr, input logic [7:0] data,
                         input logic stop, input int delay, input logic [7:0] rbuf, input logic err,
                         input bit drop);
        bit ok;
        wait_enable(ok);
        chk("enable_seen", 32'(ok), 1);
        if (ok) begin
            chk("gnt", gnt, 1 << c);
            chk("m_mode", m_mode, mode);
            chk("m_slave_addr", m_slave_addr, addr);
            chk("m_data", m_data, data);
            chk("m_stop", m_stop, stop);
            m_busy = 1'b1;
            @(negedge clk);
            chk("enable_one_cycle", m_enable, 0);
            repeat (delay) @(negedge clk);
            m_error = err;
            @(negedge clk);
            m_done     = 1'b1;
            m_recv_buf = rbuf;
            @(negedge clk);
            m_done     = 1'b0;
            m_busy     = 1'b0;
            m_error    = 1'b0;
            m_recv_buf = 8'hEE;
            check_rsp();
            chk("gnt_in_respond", gnt, 1 << c);
            if (drop) req[c] = 1'b0;
            @(negedge clk);
            chk("rsp_pulse_end", rsp_valid, 0);
            chk("gnt_cleared", gnt, 0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit ok;
        int k;
        int lat;
        int en_cnt;

        reset_n    = 1'b0;
        req        = '0;
        req_mode   = '0;
        req_stop   = '0;
        req_addr   = '0;
        req_data   = '0;
        m_busy     = 1'b0;
        m_done     = 1'b0;
        m_error    = 1'b0;
        m_recv_buf = 8'h00;

        // All clients request from reset; expected service order 0,1,2,3,0.
        for (int c = 0; c < N; c++)
            post(c, MODE_WRITE, 7'(7'h20 + c), 8'(8'h30 + c), 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        post(0, MODE_WRITE, 7'h20, 8'h30, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        chk("reset_gnt", gnt, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        chk("reset_rsp_flags", {rsp_error, rsp_timeout}, 0);
        chk("reset_m_enable", m_enable, 0);
        chk("reset_m_ops", {m_mode, m_stop, m_slave_addr, m_data}, 0);
        reset_n = 1'b1;

        for (int c = 0; c < N; c++)
            serve(c, MODE_WRITE, 7'(7'h20 + c), 8'(8'h30 + c), 1'b1, 1, 8'h00, 1'b0, 1'b0);
        req[3:1] = '0;
        serve(0, MODE_WRITE, 7'h20, 8'h30, 1'b1, 1, 8'h00, 1'b0, 1'b1);

        // Single write from client 2; the stale master buffer must not leak into rsp_data.
        post(2, MODE_WRITE, 7'h50, 8'hA5, 1'b1, 8'h77, 1'b0, 1'b0, 1'b1);
        serve(2, MODE_WRITE, 7'h50, 8'hA5, 1'b1, 3, 8'h77, 1'b0, 1'b1);

        post(0, MODE_READ, 7'h3C, 8'h00, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b1);
        serve(0, MODE_READ, 7'h3C, 8'h00, 1'b1, 2, 8'h5A, 1'b0, 1'b1);

        // NACK followed by a normal read from another client.
        post(1, MODE_WRITE, 7'h11, 8'h22, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
        serve(1, MODE_WRITE, 7'h11, 8'h22, 1'b1, 2, 8'h00, 1'b1, 1'b1);
        post(3, MODE_READ, 7'h44, 8'h00, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1);
        serve(3, MODE_READ, 7'h44, 8'h00, 1'b0, 4, 8'hC3, 1'b0, 1'b1);

        // Timeout: master stays busy and never signals done.
        post(2, MODE_WRITE, 7'h60, 8'h99, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);
        wait_enable(ok);
        chk("to_enable_seen", 32'(ok), 1);
        chk("to_gnt", gnt, 4'b0100);
        m_busy = 1'b1;
        lat    = 0;
        k      = 1;
        en_cnt = 0;
        while (lat == 0 && k < 40) begin
            @(negedge clk);
            if (m_enable) en_cnt++;
            if (|rsp_valid) lat = k;
            k++;
        end
        chk("to_latency", lat, 17);
        chk("to_no_reissue", en_cnt, 0);
        check_rsp();
        req[2] = 1'b0;
        post(3, MODE_WRITE, 7'h61, 8'h5C, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        en_cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (m_enable) en_cnt++;
        end
        chk("busy_blocks_issue", en_cnt, 0);
        m_busy = 1'b0;
        serve(3, MODE_WRITE, 7'h61, 8'h5C, 1'b0, 1, 8'h00, 1'b0, 1'b1);

        // Reset during WAIT_DONE: outputs clear at once and no response is produced.
        post(1, MODE_READ, 7'h12, 8'h34, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        wait_enable(ok);
        chk("rst_enable_seen", 32'(ok), 1);
        m_busy = 1'b1;
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_m_ops", {m_mode, m_stop, m_slave_addr, m_data}, 0);
        chk("rst_m_enable", m_enable, 0);
        chk("rst_rsp", {rsp_valid, rsp_data, rsp_error, rsp_timeout}, 0);
        m_busy = 1'b0;
        req    = '0;
        post(0, MODE_WRITE, 7'h70, 8'hAB, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int c = 1; c < N; c++)
            post(c, MODE_WRITE, 7'h71, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        en_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (|rsp_valid) en_cnt++;
        end
        chk("rst_no_rsp", en_cnt, 0);
        reset_n = 1'b1;
        serve(0, MODE_WRITE, 7'h70, 8'hAB, 1'b1, 1, 8'h00, 1'b0, 1'b1);
        req = '0;
        repeat (5) @(negedge clk);
        chk("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
